down_counter_8bit_async_reset: RTL
==================================

// Module: down_counter_8bit_async_reset
// PURPOSE
//  Loadable down-counter: the decrementing counterpart of the up-counting
//  8-bit micro-benchmark counter. Counts a loaded value down to zero and
//  flags terminal count. Supports one-shot or periodic (auto-reload) mode.
//  Sits in the micro-benchmark counter suite as a timer/terminal-count
//  primitive for FPGA flow regression.
// PARAMETERS
//  WIDTH     8   counter width in bits
//  PERIODIC  0   0 = one-shot (stop at zero), 1 = auto-reload from latched value
// PORTS
//  clk         input   1      rising-edge clock; single clock domain
//  reset       input   1      asynchronous, active-low reset
//  start       input   1      1-cycle pulse: latch load_value and begin counting
//  stop        input   1      1-cycle pulse: abort counting, return to IDLE
//  enable      input   1      count-enable; decrement only when high
//  load_value  input   WIDTH  start value, sampled only on the start cycle
//  count       output  WIDTH  current counter value (registered)
//  tc          output  1      terminal-count pulse, 1 cycle (registered)
//  busy        output  1      high while state == RUN
//  done        output  1      high while state == DONE (one-shot only)
// BEHAVIOUR
//  - Reset low (async assert, sync-safe deassert): count=0, reload_q=0,
//    tc=0, busy=0, done=0, state=IDLE. Reset mid-count aborts immediately.
//  - States: IDLE, RUN, DONE. All outputs are registered; no comb paths.
//  - IDLE/DONE + start: count<=load_value, reload_q<=load_value,
//    state->RUN, done<=0. Latency: count shows load_value 1 cycle after start.
//  - RUN, enable=1, count>0: count<=count-1. When count goes 1->0, tc=1 for
//    exactly the cycle count first reads 0.
//  - RUN, enable=0: count and state hold; tc=0.
//  - RUN, count==0, enable=1:
//      PERIODIC=0: state->DONE, done=1, count holds 0 (never wraps to max).
//      PERIODIC=1: count<=reload_q, stay RUN. Period = reload_q+1 enabled cycles.
//  - load_value==0 on start: count=0 next cycle, tc=1 in that cycle
//    (zero-length count). The next enabled cycle then follows the rule above.
//  - start while RUN: restart from the new load_value; no tc for the aborted run.
//  - stop (any state): state->IDLE, count holds its value, tc=0, busy=0, done=0.
//  - start and stop in the same cycle: stop wins.
//  - tc is never asserted in IDLE or DONE.
//  - Arithmetic: unsigned WIDTH bits. The decrement is never applied at 0,
//    so underflow cannot occur.
// STRUCTURE
//  - Shared package counter_pkg:
//      state encoding ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10
//      CNT_WIDTH_DEFAULT=8
//  - One sub-module: down_counter_core. It holds the count/reload_q datapath
//    (load, decrement, reload, zero detect) and takes its control from the
//    FSM in this top module.
// TESTING
//  1. Reset low for 100 ns at t=0, then start with load_value=8'd5 and
//     enable=1 -> count 5,4,3,2,1,0; tc=1 only on the count==0 cycle;
//     done=1 on the next cycle; count stays 0.
//  2. Run as in test 1 with enable toggling 1,0,1,0,... -> count decrements
//     only on enable=1 cycles; tc is asserted 10 cycles after count shows 5.
//  3. PERIODIC=1, load_value=8'd3, enable=1 for 20 cycles -> count
//     3,2,1,0,3,2,... ; tc pulses every 4 cycles; busy stays 1.
//  4. Start with load_value=8'd200; pull reset low when count==8'd150 ->
//     count=0, busy=0, tc=0 asynchronously, before the next clk edge.
//  5. Start with load_value=8'd0 -> count=0 and tc=1 on the next cycle;
//     done=1 on the following enabled cycle.
//  6. In RUN at count=8'd10, assert start and stop in the same cycle -> IDLE,
//     count holds 10. Then start with load_value=8'd7 mid-RUN -> count=7,
//     no tc glitch.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the micro-benchmark counter suite:
// FSM state encoding and default counter width.
package counter_pkg;

  localparam int CNT_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/down_counter_core.sv
// Count/reload datapath for the down-counter: load, decrement, reload and
// zero/one detection. All sequencing decisions come from the enclosing FSM.
module down_counter_core
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic             reload_en,
  input  logic             dec_en,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             count_zero,
  output logic             count_one,
  output logic             reload_zero
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;

  // Load has priority; the FSM never requests decrement while count is zero.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    if (load_en) begin
      count_d  = load_value;
      reload_d = load_value;
    end else if (reload_en) begin
      count_d = reload_q;
    end else if (dec_en) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      reload_q <= '0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
    end
  end

  assign count       = count_q;
  assign count_zero  = (count_q == '0);
  assign count_one   = (count_q == WIDTH'(1));
  assign reload_zero = (reload_q == '0);

endmodule

// File: rtl/down_counter_8bit_async_reset.sv
// Loadable down-counter with terminal-count pulse, one-shot or auto-reload.
// The FSM here drives the datapath in down_counter_core.
module down_counter_8bit_async_reset
  import counter_pkg::*;
#(
  parameter int WIDTH    = CNT_WIDTH_DEFAULT,
  parameter bit PERIODIC = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_e state_q, state_d;
  logic   tc_q, tc_d;
  logic   load_en, reload_en, dec_en;
  logic   count_zero, count_one, reload_zero;

  down_counter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .load_en    (load_en),
    .reload_en  (reload_en),
    .dec_en     (dec_en),
    .load_value (load_value),
    .count      (count),
    .count_zero (count_zero),
    .count_one  (count_one),
    .reload_zero(reload_zero)
  );

  // tc is registered alongside the count, so it marks the cycle count first reads 0.
  always_comb begin
    state_d   = state_q;
    tc_d      = 1'b0;
    load_en   = 1'b0;
    reload_en = 1'b0;
    dec_en    = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
    end else if (start) begin
      load_en = 1'b1;
      state_d = ST_RUN;
      tc_d    = (load_value == '0);
    end else begin
      case (state_q)
        ST_RUN: begin
          if (enable) begin
            if (!count_zero) begin
              dec_en = 1'b1;
              tc_d   = count_one;
            end else if (PERIODIC) begin
              reload_en = 1'b1;
              tc_d      = reload_zero;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
    end
  end

  assign tc   = tc_q;
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule
